mem_load_unit: RTL

Load-side counterpart of the store byte-merge path. It accepts one load request at a time from the execute stage and issues a word-aligned read on the data-memory request/grant/response interface. It then extracts and sign- or zero-extends the addressed byte, halfword or word from the returned word, and delivers it to writeback with its destination register. Misaligned and illegal loads are detected without a memory access, and a response timeout is enforced.

---
 rtl/mem_load_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_load_unit.sv
// mem_load_unit
//   Accepts one load request at a time from execute. It issues a word-aligned
//   read on the data-memory req/gnt/rvalid interface, then extracts and sign- or
//   zero-extends the addressed byte, halfword or word. The result goes to
//   writeback together with the destination register. Misaligned and illegal
//   loads fault without touching memory. A missing response faults after
//   TIMEOUT_CYCLES WAIT cycles.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_addr, req_funct3, req_rd       byte address, load type, destination
//   flush                              abort the in-flight load (no writeback)
//   mem_req/mem_addr/mem_gnt           word-aligned read request and grant
//   mem_rvalid/mem_rdata               read response
//   wb_valid/wb_data/wb_rd/wb_fault    one-cycle writeback result
//                                      (fault: 00 ok, 01 misaligned,
//                                       10 illegal funct3, 11 timeout)
module mem_load_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   counter_reg, counter_next;
  logic               killed_reg, killed_next;

  logic [1:0]         off_reg;
  logic [2:0]         funct3_reg;
  logic [4:0]         rd_reg;
  logic [31:0]        mem_addr_reg;
  logic [31:0]        wb_data_reg;
  logic [4:0]         wb_rd_reg;
  logic [1:0]         wb_fault_reg;

  logic               accept;
  logic               illegal;
  logic               misaligned;
  logic [1:0]         req_fault;
  logic               timeout_hit;
  logic [31:0]        shifted;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_data;

  // Request classification; illegal funct3 outranks misalignment.
  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: begin
        illegal    = 1'b0;
        misaligned = req_addr[0];
      end
      3'b010: begin
        illegal    = 1'b0;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal)
      req_fault = 2'b10;
    else if (misaligned)
      req_fault = 2'b01;
    else
      req_fault = 2'b00;
  end

  assign accept      = (state_reg == S_IDLE) && req_valid;
  assign timeout_hit = (counter_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Byte/halfword lane extraction from the returned word.
  always_comb begin
    shifted  = mem_rdata >> {off_reg, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    killed_next  = killed_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid)
          state_next = (req_fault != 2'b00) ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (mem_gnt) begin
          // A flush coinciding with the grant still aborts the load; the read
          // is already committed, so it is drained silently in WAIT.
          state_next   = S_WAIT;
          counter_next = '0;
          killed_next  = flush;
        end else if (flush) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush)
          killed_next = 1'b1;
        if (mem_rvalid || timeout_hit) begin
          state_next  = (killed_reg || flush) ? S_IDLE : S_RESP;
          killed_next = 1'b0;
        end else begin
          counter_next = counter_reg + CNT_W'(1);
        end
      end
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      counter_reg <= '0;
      killed_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      killed_reg  <= killed_next;
    end
  end

  // Request latches and registered writeback payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off_reg      <= 2'b00;
      funct3_reg   <= 3'b000;
      rd_reg       <= 5'd0;
      mem_addr_reg <= 32'h0;
      wb_data_reg  <= 32'h0;
      wb_rd_reg    <= 5'd0;
      wb_fault_reg <= 2'b00;
    end else begin
      if (accept) begin
        off_reg      <= req_addr[1:0];
        funct3_reg   <= req_funct3;
        rd_reg       <= req_rd;
        mem_addr_reg <= {req_addr[31:2], 2'b00};
        if (req_fault != 2'b00) begin
          wb_data_reg  <= 32'h0;
          wb_rd_reg    <= req_rd;
          wb_fault_reg <= req_fault;
        end
      end
      if (state_reg == S_WAIT && state_next == S_RESP) begin
        wb_rd_reg <= rd_reg;
        if (mem_rvalid) begin
          wb_data_reg  <= load_data;
          wb_fault_reg <= 2'b00;
        end else begin
          wb_data_reg  <= 32'h0;
          wb_fault_reg <= 2'b11;
        end
      end
    end
  end

  assign req_ready = (state_reg == S_IDLE);
  assign mem_req   = (state_reg == S_REQ);
  assign wb_valid  = (state_reg == S_RESP);
  assign mem_addr  = mem_addr_reg;
  assign wb_data   = wb_data_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_fault  = wb_fault_reg;

endmodule
